// File: rtl/code_lock_seq.sv
// code_lock_seq: reprogrammable N-digit sequential code lock with failed-attempt counter.
// Latency: all outputs registered. O, Err, Locked and Tries change the cycle after the edge that accepts the deciding digit.
// Backpressure: none. A digit is accepted on every cycle where HAB=1 and Valid=1, and is ignored during LOCKOUT.
//
// Ports:
//   Clock   system clock, rising edge
//   Reset   asynchronous active-high reset; also restores DEFAULT_CODE
//   HAB     enable; when low, Valid is ignored and any partial entry/programming is dropped
//   COD     1 = program a new code (only while open), 0 = verify
//   A       digit value, sampled with Valid
//   Valid   one-cycle digit strobe
//   O       lock open
//   Err     one-cycle pulse after a wrong N-digit sequence
//   Locked  lockout active
//   Tries   failed-attempt count, saturating at MAX_TRIES
//   Prog    programming sequence in progress
//
// Optional feature: define CODE_LOCK_LOCKOUT_EN to enter LOCKOUT after MAX_TRIES failures.
// Without it, Locked is tied low and entry continues with Tries saturated.

module code_lock_seq #(
    parameter int               W            = 4,
    parameter int               N            = 4,
    parameter logic [N*W-1:0]   DEFAULT_CODE = {(N*W){1'b0}},
    parameter int               MAX_TRIES    = 3,
    parameter int               OPEN_CYCLES  = 32,
    parameter int               LOCK_CYCLES  = 64
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             HAB,
    input  logic                             COD,
    input  logic [W-1:0]                     A,
    input  logic                             Valid,
    output logic                             O,
    output logic                             Err,
    output logic                             Locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   Tries,
    output logic                             Prog
);

    localparam int TW   = $clog2(MAX_TRIES + 1);
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMW  = $clog2(TMAX + 1);

    localparam logic [IW-1:0]  LAST_IDX  = IW'(N - 1);
    localparam logic [TW-1:0]  TRIES_MAX = TW'(MAX_TRIES);
    localparam logic [TMW-1:0] OPEN_LOAD = TMW'(OPEN_CYCLES);
`ifdef CODE_LOCK_LOCKOUT_EN
    localparam logic [TMW-1:0] LOCK_LOAD = TMW'(LOCK_CYCLES);
`endif

    typedef enum logic [1:0] {IDLE, ENTER, OPEN, LOCKOUT} state_t;

    state_t           state_q, state_n, state_e;
    logic [IW-1:0]    idx_q, idx_n, idx_e;
    logic             match_q, match_n, match_e;
    logic [TW-1:0]    tries_q, tries_n, tries_e;
    logic [TMW-1:0]   tmr_q, tmr_n;
    logic [N*W-1:0]   code_q, code_n;
    logic [N*W-1:0]   shadow_q, shadow_n, shadow_w;
    logic             prog_q, prog_n;
    logic             digit_ok;
    logic             fail;
    logic             o_n, err_n, locked_n;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            match_q  <= 1'b1;
            tries_q  <= '0;
            tmr_q    <= '0;
            code_q   <= DEFAULT_CODE;
            shadow_q <= '0;
            prog_q   <= 1'b0;
            O        <= 1'b0;
            Err      <= 1'b0;
            Locked   <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            match_q  <= match_n;
            tries_q  <= tries_n;
            tmr_q    <= tmr_n;
            code_q   <= code_n;
            shadow_q <= shadow_n;
            prog_q   <= prog_n;
            O        <= o_n;
            Err      <= err_n;
            Locked   <= locked_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        match_n  = match_q;
        tries_n  = tries_q;
        tmr_n    = tmr_q;
        code_n   = code_q;
        shadow_n = shadow_q;
        prog_n   = prog_q;
        fail     = 1'b0;
        digit_ok = 1'b0;
        shadow_w = shadow_q;

        // Resolve timer expiry first, so that a digit arriving on the
        // expiry edge is handled as the first digit in IDLE.
        state_e  = state_q;
        idx_e    = idx_q;
        match_e  = match_q;
        tries_e  = tries_q;
        if (state_q == OPEN || state_q == LOCKOUT) begin
            if (tmr_q <= TMW'(1)) begin
                state_e = IDLE;
                idx_e   = '0;
                match_e = 1'b1;
                if (state_q == LOCKOUT) begin
                    tries_e = '0;
                end
                state_n = IDLE;
                tmr_n   = '0;
                prog_n  = 1'b0;
            end else begin
                tmr_n = tmr_q - TMW'(1);
            end
        end
        idx_n   = idx_e;
        match_n = match_e;
        tries_n = tries_e;

        if (!HAB) begin
            idx_n   = '0;
            match_n = 1'b1;
            prog_n  = 1'b0;
            if (state_n == ENTER) begin
                state_n = IDLE;
            end
        end else if (Valid) begin
            case (state_e)
                IDLE, ENTER: begin
                    // The running match flag lets every digit be keyed in
                    // even after a mismatch; the verdict comes only at digit N.
                    digit_ok = match_e & (A == code_q[idx_e*W +: W]);
                    if (idx_e == LAST_IDX) begin
                        idx_n   = '0;
                        match_n = 1'b1;
                        if (digit_ok) begin
                            state_n = OPEN;
                            tries_n = '0;
                            tmr_n   = OPEN_LOAD;
                        end else begin
                            fail    = 1'b1;
                            state_n = IDLE;
`ifdef CODE_LOCK_LOCKOUT_EN
                            if (tries_e + 1'b1 >= TRIES_MAX) begin
                                tries_n = TRIES_MAX;
                                state_n = LOCKOUT;
                                tmr_n   = LOCK_LOAD;
                            end else begin
                                tries_n = tries_e + 1'b1;
                            end
`else
                            tries_n = (tries_e == TRIES_MAX) ? TRIES_MAX : tries_e + 1'b1;
`endif
                        end
                    end else begin
                        idx_n   = idx_e + IW'(1);
                        match_n = digit_ok;
                        state_n = ENTER;
                    end
                end
                OPEN: begin
                    if (COD) begin
                        shadow_w               = shadow_q;
                        shadow_w[idx_e*W +: W] = A;
                        shadow_n               = shadow_w;
                        if (idx_e == LAST_IDX) begin
                            // Commit ends the open period immediately.
                            code_n  = shadow_w;
                            idx_n   = '0;
                            prog_n  = 1'b0;
                            state_n = IDLE;
                            tmr_n   = '0;
                        end else begin
                            idx_n  = idx_e + IW'(1);
                            prog_n = 1'b1;
                        end
                    end
                end
                default: begin
                    // LOCKOUT: digits ignored
                end
            endcase
        end
    end

    // Output logic (registered in the state register process)
    always_comb begin
        o_n   = (state_n == OPEN);
        err_n = fail;
`ifdef CODE_LOCK_LOCKOUT_EN
        locked_n = (state_n == LOCKOUT);
`else
        locked_n = 1'b0;
`endif
    end

    assign Tries = tries_q;
    assign Prog  = prog_q;

endmodule

// File: tb/tb_code_lock_seq.sv
module tb_code_lock_seq;

    localparam int W           = 4;
    localparam int N           = 4;
    localparam int MAX_TRIES   = 3;
    localparam int OPEN_CYCLES = 32;
    localparam int LOCK_CYCLES = 64;
    localparam int TW          = $clog2(MAX_TRIES + 1);

    logic          Clock = 1'b0;
    logic          Reset;
    logic          HAB;
    logic          COD;
    logic [W-1:0]  A;
    logic          Valid;
    logic          O;
    logic          Err;
    logic          Locked;
    logic [TW-1:0] Tries;
    logic          Prog;

    int ncmp = 0;
    int nmis = 0;

    // Reference model: digits held in queues, verdict on the whole sequence.
    int m_code[N];
    int m_entered[$];
    int m_shadow[$];
    int m_open_left;
    int m_lock_left;
    int m_tries;
    bit m_err;

    code_lock_seq dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .HAB    (HAB),
        .COD    (COD),
        .A      (A),
        .Valid  (Valid),
        .O      (O),
        .Err    (Err),
        .Locked (Locked),
        .Tries  (Tries),
        .Prog   (Prog)
    );

    always #5 Clock = ~Clock;

    task automatic model_reset();
        foreach (m_code[i]) m_code[i] = 0;
        m_entered.delete();
        m_shadow.delete();
        m_open_left = 0;
        m_lock_left = 0;
        m_tries     = 0;
        m_err       = 0;
    endtask

    task automatic model_step();
        bit ok;
        m_err = 0;
        if (m_open_left > 0) begin
            m_open_left--;
            if (m_open_left == 0) m_shadow.delete();
        end
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_tries = 0;
        end
        if (!HAB) begin
            m_entered.delete();
            m_shadow.delete();
        end else if (Valid && m_lock_left == 0) begin
            if (m_open_left > 0) begin
                if (COD) begin
                    m_shadow.push_back(int'(A));
                    if (m_shadow.size() == N) begin
                        foreach (m_code[i]) m_code[i] = m_shadow[i];
                        m_shadow.delete();
                        m_open_left = 0;
                    end
                end
            end else begin
                m_entered.push_back(int'(A));
                if (m_entered.size() == N) begin
                    ok = 1;
                    foreach (m_code[i]) if (m_entered[i] != m_code[i]) ok = 0;
                    m_entered.delete();
                    if (ok) begin
                        m_open_left = OPEN_CYCLES;
                        m_tries     = 0;
                    end else begin
                        m_err = 1;
                        if (m_tries < MAX_TRIES) m_tries++;
`ifdef CODE_LOCK_LOCKOUT_EN
                        if (m_tries == MAX_TRIES) m_lock_left = LOCK_CYCLES;
`endif
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        ncmp++;
        assert (got === exp)
        else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("O",      16'(O),      16'(m_open_left > 0));
        check("Err",    16'(Err),    16'(m_err));
        check("Locked", 16'(Locked), 16'(m_lock_left > 0));
        check("Tries",  16'(Tries),  16'(m_tries));
        check("Prog",   16'(Prog),   16'(m_shadow.size() > 0));
    endtask

    task automatic step(input bit hab, input bit cod, input int a, input bit valid);
        HAB   = hab;
        COD   = cod;
        A     = a[W-1:0];
        Valid = valid;
        @(posedge Clock);
        model_step();
        #1 check_all();
    endtask

    task automatic key(input int d, input bit cod);
        step(1'b1, cod, d, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic key4(input int d0, input int d1, input int d2, input int d3, input bit cod);
        key(d0, cod);
        key(d1, cod);
        key(d2, cod);
        key(d3, cod);
    endtask

    // Asynchronous reset pulse, applied between clock edges.
    task automatic pulse_reset();
        Reset = 1'b1;
        #2;
        model_reset();
        check_all();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        int a;
        Reset = 1'b1;
        HAB   = 1'b0;
        COD   = 1'b0;
        A     = '0;
        Valid = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge Clock);
        Reset = 1'b0;

        // Default code opens; then a digit on the expiry edge starts a new entry.
        key4(0, 0, 0, 0, 1'b0);
        idle(OPEN_CYCLES - 1);
        key4(0, 0, 0, 0, 1'b0);
        idle(OPEN_CYCLES + 2);

        // Three wrong sequences.
        for (int k = 0; k < 3; k++) begin
            key4(0, 1, 0, 0, 1'b0);
            idle(2);
        end
        key4(0, 0, 0, 0, 1'b0);
        idle(LOCK_CYCLES + 4);

        // Open, then partial programming abandoned by timeout.
        key4(0, 0, 0, 0, 1'b0);
        key(9, 1'b1);
        key(8, 1'b1);
        idle(OPEN_CYCLES);
        key4(0, 0, 0, 0, 1'b0);

        // Full programming to 9876 while open.
        key4(9, 8, 7, 6, 1'b1);
        idle(2);
        key4(0, 0, 0, 0, 1'b0);
        key4(9, 8, 7, 6, 1'b0);
        idle(3);

        // Reset while open restores the default code.
        pulse_reset();

        // HAB drop discards a partial entry.
        key(0, 1'b0);
        key(0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        key(0, 1'b0);
        key(0, 1'b0);
        idle(1);
        key(0, 1'b0);
        key(0, 1'b0);
        idle(OPEN_CYCLES + 2);

        // Reset mid-entry and after accumulated failures/lockout.
        key(0, 1'b0);
        key(1, 1'b0);
        pulse_reset();
        for (int k = 0; k < 3; k++) key4(1, 1, 1, 1, 1'b0);
        idle(5);
        pulse_reset();
        key4(0, 0, 0, 0, 1'b0);
        idle(OPEN_CYCLES + 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 1));
            step(($urandom_range(0, 19) != 0), $urandom_range(0, 1) == 1, a, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule

// File: doc/code_lock_seq.md
# code_lock_seq

Parametrised sequential code lock, successor of the fixed 4-bit single-digit lock circuit: accepts a keyed sequence of N digits of W bits, compares it against a stored, reprogrammable code, drives the open output and counts failed attempts. Sits between the keypad debouncer/strobe logic and the actuator driver, with the lock top level in a single clock domain.

## Interface
- W, 4, digit width in bits
- N, 4, digits per code (≥1)
- DEFAULT_CODE, {N{4'h0}} sized N*W, code loaded at reset; digit 0 in bits [W-1:0]
- MAX_TRIES, 3, failed attempts before lockout (≥1)
- OPEN_CYCLES, 32, cycles O stays high
- LOCK_CYCLES, 64, lockout duration in cycles
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- HAB  in  1  enable; 0 ignores Valid and clears partial entry
- COD  in  1  1 = program mode (honoured only in OPEN), 0 = verify
- A  in  W  digit value
- Valid  in  1  one-cycle digit strobe; A sampled when HAB=1 and Valid=1
- O  out  1  lock open
- Err  out  1  one-cycle pulse on failed sequence
- Locked  out  1  lockout active
- Tries  out  $clog2(MAX_TRIES+1)  failed-attempt count
- Prog  out  1  programming sequence in progress

## Operation
- Reset values: state IDLE, code reg = DEFAULT_CODE, digit index 0, match flag 1, Tries=0, O=0, Err=0, Locked=0, Prog=0, timers 0.
- States: IDLE, ENTER, OPEN, LOCKOUT.
- IDLE/ENTER: each accepted digit compared with code digit[index]; match flag &= equal; index++; IDLE→ENTER on first digit. COD ignored.
- Nth digit accepted: match → OPEN, Tries←0, open timer←OPEN_CYCLES. Mismatch → Err pulse, Tries+1, index←0, IDLE; if Tries+1 == MAX_TRIES → LOCKOUT (see Configuration).
- Comparison uses the full sequence: no early reject; Err only after Nth digit.
- OPEN: O=1. Digit accepted with COD=1 starts/continues programming (Prog=1); digits written into a shadow register; Nth digit commits shadow → code reg, → IDLE. Digits with COD=0 in OPEN ignored.
- Open timer expiry → IDLE; a partial programming sequence is discarded, old code kept.
- LOCKOUT: all Valid ignored; Locked=1; on timer expiry Tries←0, → IDLE.
- HAB=0: index←0, match←1, shadow discarded, Prog←0, state ENTER→IDLE; OPEN and LOCKOUT timers keep running.
- Tries saturates at MAX_TRIES; never wraps.

## Timing
- All outputs registered; state updates on the edge sampling the digit.
- O rises the cycle after the edge accepting the Nth matching digit; high exactly OPEN_CYCLES cycles unless programming commit ends OPEN earlier (O falls the cycle after commit edge).
- Err high exactly one cycle, same cycle Tries updates.
- Locked high exactly LOCK_CYCLES cycles, starting with the Err cycle.
- Back-to-back Valid on consecutive cycles accepted, one digit per cycle.
- Valid on the timer-expiry edge: treated as arriving in the new state (IDLE), i.e. accepted as digit 0.
- Reset mid-sequence or mid-programming: immediate return to reset values, including code reg = DEFAULT_CODE.

## Configuration
- CODE_LOCK_LOCKOUT_EN defined: MAX_TRIES failures enter LOCKOUT as above.
- Undefined: no LOCKOUT state, Locked tied 0; Tries saturates at MAX_TRIES, Err still pulses, entry continues; Tries cleared only by successful open or Reset.

## Test plan
- Defaults, HAB=1, COD=0: digits 0,0,0,0 → O=1 the cycle after 4th digit, for 32 cycles; Tries=0.
- Digits 0,1,0,0 three times → Err pulse each, Tries 1,2,3; with macro Locked=1 for 64 cycles, digits ignored, then Tries=0; without macro Locked=0, Tries stays 3.
- Open, COD=1, digits 9,8,7,6 → Prog=1 during entry, commit, O=0; then 0,0,0,0 → Err; 9,8,7,6 → O=1.
- Open, COD=1, digits 9,8 then wait out OPEN_CYCLES → code unchanged; 0,0,0,0 opens.
- Digits 0,0, HAB=0 one cycle, HAB=1, digits 0,0 → no open, no Err; then 0,0 → O=1.
- Reset asserted mid-LOCKOUT and mid-entry → all outputs 0 immediately, DEFAULT_CODE restored.
